// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath types
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Memory-stage access phase, shared with hazard and debug logic
  typedef enum logic {
    IDLE  = 1'b0,
    FINAL = 1'b1
  } lc3b_mem_state;

  function automatic lc3b_word word_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - data-memory port between memory stage and data memory
interface mem_stage_ctrl_if;
  import lc3b_types::*;

  lc3b_word   dmem_address;
  lc3b_word   dmem_wdata;
  logic       dmem_read;
  logic       dmem_write;
  logic [1:0] dmem_byte_enable;
  lc3b_word   dmem_rdata;
  logic       dmem_resp;

  modport master (
    output dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );

endinterface

// File: rtl/mem_data_format.sv
// rtl/mem_data_format.sv - byte-lane enables, store replication and load extension
module mem_data_format
  import lc3b_types::*;
(
  input  logic       addr_lsb,
  input  logic       is_byte,
  input  lc3b_word   dmem_rdata,
  input  lc3b_word   store_data,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata,
  output lc3b_word   load_data
);

  // Word access by default; a byte access picks the lane from the address LSB
  always_comb begin
    byte_enable = 2'b11;
    wdata       = store_data;
    load_data   = dmem_rdata;
    if (is_byte) begin
      byte_enable = addr_lsb ? 2'b10 : 2'b01;
      wdata       = {store_data[7:0], store_data[7:0]};
      load_data   = addr_lsb ? {8'h00, dmem_rdata[15:8]} : {8'h00, dmem_rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - LC-3b memory-stage access controller with stall generation
module mem_stage_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  is_ldi_in,
  input  logic                  is_sti_in,
  input  logic                  is_ldb_stb_in,
  input  lc3b_word              mem_addr_in,
  input  lc3b_word              store_data_in,
  mem_stage_ctrl_if.master      dmem,
  output lc3b_word              mem_data_out,
  output logic                  stall_pipeline,
  output logic [CNT_W-1:0]      mem_stall_cycles,
  output logic [CNT_W-1:0]      mem_accesses
);

  lc3b_mem_state state_q, state_d;
  lc3b_word      ptr_q;
  logic [CNT_W-1:0] stall_cnt_q, access_cnt_q;

  logic       req, is_read, is_write, indirect;
  logic       fmt_is_byte;
  logic [1:0] fmt_be;
  lc3b_word   fmt_wdata, fmt_load;

  lc3b_word   addr_c, wdata_c, dout_c;
  logic       rd_c, wr_c, stall_c, final_resp, ptr_load;
  logic [1:0] be_c;

  // Simultaneous read and write resolves to a read
  assign req         = mem_read_in | mem_write_in;
  assign is_read     = mem_read_in;
  assign is_write    = mem_write_in & ~mem_read_in;
  assign indirect    = is_read ? is_ldi_in : is_sti_in;
  // Only a direct access in IDLE may be a byte access; pointer and final indirect accesses are words
  assign fmt_is_byte = is_ldb_stb_in & ~indirect & (state_q == IDLE);

  mem_data_format u_fmt (
    .addr_lsb    (mem_addr_in[0]),
    .is_byte     (fmt_is_byte),
    .dmem_rdata  (dmem.dmem_rdata),
    .store_data  (store_data_in),
    .byte_enable (fmt_be),
    .wdata       (fmt_wdata),
    .load_data   (fmt_load)
  );

  // Next state and memory request outputs; everything forced low while reset is asserted
  always_comb begin
    state_d    = state_q;
    addr_c     = '0;
    wdata_c    = '0;
    dout_c     = '0;
    be_c       = 2'b00;
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    stall_c    = 1'b0;
    final_resp = 1'b0;
    ptr_load   = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (req && indirect) begin
            addr_c  = word_align(mem_addr_in);
            rd_c    = 1'b1;
            be_c    = 2'b11;
            stall_c = 1'b1;
            if (dmem.dmem_resp) begin
              ptr_load = 1'b1;
              state_d  = FINAL;
            end
          end else if (req) begin
            addr_c     = is_ldb_stb_in ? mem_addr_in : word_align(mem_addr_in);
            rd_c       = is_read;
            wr_c       = is_write;
            be_c       = fmt_be;
            wdata_c    = is_write ? fmt_wdata : '0;
            stall_c    = ~dmem.dmem_resp;
            final_resp = dmem.dmem_resp;
            if (dmem.dmem_resp && is_read) dout_c = fmt_load;
          end
        end
        default: begin
          addr_c     = word_align(ptr_q);
          rd_c       = is_read;
          wr_c       = is_write;
          be_c       = 2'b11;
          wdata_c    = is_write ? store_data_in : '0;
          stall_c    = ~dmem.dmem_resp;
          final_resp = dmem.dmem_resp;
          if (dmem.dmem_resp && is_read) dout_c = dmem.dmem_rdata;
          if (dmem.dmem_resp) state_d = IDLE;
        end
      endcase
    end
  end

  assign dmem.dmem_address     = addr_c;
  assign dmem.dmem_wdata       = wdata_c;
  assign dmem.dmem_read        = rd_c;
  assign dmem.dmem_write       = wr_c;
  assign dmem.dmem_byte_enable = be_c;
  assign mem_data_out          = dout_c;
  assign stall_pipeline        = stall_c;
  assign mem_stall_cycles      = stall_cnt_q;
  assign mem_accesses          = access_cnt_q;

  // Access phase register and captured indirect pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ptr_load) ptr_q <= dmem.dmem_rdata;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      access_cnt_q <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (final_resp && (access_cnt_q != {CNT_W{1'b1}}))
        access_cnt_q <= access_cnt_q + CNT_W'(1);
    end
  end

endmodule
